// File: rtl/regfile_pkg.sv
// Shared types and width defaults for the register-file writeback arbiter.
package regfile_pkg;

   localparam int unsigned DefaultAddressWidth = 5;
   localparam int unsigned DefaultDataWidth    = 32;

   typedef logic [DefaultAddressWidth-1:0] reg_idx_t;

   typedef struct packed {
      logic                        valid;
      reg_idx_t                    rd;
      logic [DefaultDataWidth-1:0] data;
   } wb_req_t;

   typedef enum logic {
      GNT_ALU,
      GNT_LSU
   } grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load bitmap: set on load issue, clear on LSU writeback, decode hazard flag
// and registered protocol-error pulse.
module wb_scoreboard #(
   parameter int unsigned AddrWidth = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 set_en_i,
   input  logic [AddrWidth-1:0] set_idx_i,
   input  logic                 clr_en_i,
   input  logic [AddrWidth-1:0] clr_idx_i,
   input  logic                 alu_wr_i,
   input  logic [AddrWidth-1:0] alu_idx_i,
   input  logic [AddrWidth-1:0] chk_rs1_i,
   input  logic [AddrWidth-1:0] chk_rs2_i,
   input  logic [AddrWidth-1:0] chk_rd_i,
   input  logic [2:0]           chk_en_i,
   output logic                 hazard_o,
   output logic                 err_o
);

   localparam int unsigned NumRegs = 2 ** AddrWidth;

   logic [NumRegs-1:0] pending_q, pending_d;
   logic               err_q, err_d;

   // Set is applied after clear so a same-index collision leaves the new load pending.
   always_comb begin
      pending_d = pending_q;
      if (clr_en_i) begin
         pending_d[clr_idx_i] = 1'b0;
      end
      if (set_en_i && (set_idx_i != '0)) begin
         pending_d[set_idx_i] = 1'b1;
      end
   end

   always_comb begin
      err_d = 1'b0;
      if (set_en_i && pending_q[set_idx_i] && !(clr_en_i && (clr_idx_i == set_idx_i))) begin
         err_d = 1'b1;
      end
      if (clr_en_i && (clr_idx_i != '0) && !pending_q[clr_idx_i]) begin
         err_d = 1'b1;
      end
      if (alu_wr_i && pending_q[alu_idx_i]) begin
         err_d = 1'b1;
      end
   end

   always_comb begin
      hazard_o = (chk_en_i[0] && pending_q[chk_rs1_i]) ||
                 (chk_en_i[1] && pending_q[chk_rs2_i]) ||
                 (chk_en_i[2] && pending_q[chk_rd_i]);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending_q <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the ALU and LSU writeback requesters onto the register file's single write port.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = DefaultAddressWidth,
   parameter int unsigned DATA_WIDTH    = DefaultDataWidth
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDRESS_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]    alu_data,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [ADDRESS_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0]    lsu_data,
   input  logic                     ld_issue,
   input  logic [ADDRESS_WIDTH-1:0] ld_issue_rd,
   input  logic [ADDRESS_WIDTH-1:0] chk_rs1,
   input  logic [ADDRESS_WIDTH-1:0] chk_rs2,
   input  logic [ADDRESS_WIDTH-1:0] chk_rd,
   input  logic [2:0]               chk_en,
   output logic                     hazard,
   output logic                     we,
   output logic [ADDRESS_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0]    wdata,
   output logic                     err
);

   typedef struct packed {
      logic                     valid;
      logic [ADDRESS_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]    data;
   } req_t;

   req_t   alu_req, lsu_req, win_req;
   grant_e gnt;
   logic   xfer;

   logic                     we_q, we_d;
   logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

   assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
   assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};

`ifdef WB_ARB_RR_EN
   grant_e last_q, last_d;

   always_comb begin
      gnt = GNT_ALU;
      if (alu_valid && lsu_valid) begin
         gnt = (last_q == GNT_ALU) ? GNT_LSU : GNT_ALU;
      end else if (lsu_valid) begin
         gnt = GNT_LSU;
      end
   end

   always_comb begin
      last_d = last_q;
      if (xfer) begin
         last_d = gnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= GNT_ALU;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      gnt = lsu_valid ? GNT_LSU : GNT_ALU;
   end
`endif

   // With no requester valid the grant parks on the ALU, so the winner's valid is the transfer.
   assign win_req   = (gnt == GNT_LSU) ? lsu_req : alu_req;
   assign xfer      = win_req.valid;
   assign alu_ready = alu_valid && (gnt == GNT_ALU);
   assign lsu_ready = lsu_valid && (gnt == GNT_LSU);

   always_comb begin
      we_d    = xfer && (win_req.rd != '0);
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (we_d) begin
         waddr_d = win_req.rd;
         wdata_d = win_req.data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign we    = we_q;
   assign waddr = waddr_q;
   assign wdata = wdata_q;

   wb_scoreboard #(
      .AddrWidth (ADDRESS_WIDTH)
   ) u_scoreboard (
      .clk_i     (clk),
      .rst_i     (rst),
      .set_en_i  (ld_issue),
      .set_idx_i (ld_issue_rd),
      .clr_en_i  (lsu_ready),
      .clr_idx_i (lsu_rd),
      .alu_wr_i  (alu_ready),
      .alu_idx_i (alu_rd),
      .chk_rs1_i (chk_rs1),
      .chk_rs2_i (chk_rs2),
      .chk_rd_i  (chk_rd),
      .chk_en_i  (chk_en),
      .hazard_o  (hazard),
      .err_o     (err)
   );

endmodule
